spi_byte_shifter: RTL and testbench

- SPI master byte engine for the MSX SPI cartridge. Sits directly downstream of the serial clock divider and consumes its divided clock output.
- Runs entirely in the Z80 clock domain. Each transition of the divided clock, or every clk cycle in fast mode, is one SCK half-period tick.
- A CPU write starts one full-duplex 8-bit exchange in SPI mode 0. It drives SCK/MOSI, samples MISO, and presents the received byte plus busy/done status to the I/O decoder.

---
 rtl/spi_byte_shifter_pkg.sv | 31 +++
 rtl/spi_byte_shifter_tick.sv | 24 ++
 rtl/spi_byte_shifter.sv | 147 ++++++++++++++
 tb/tb_spi_byte_shifter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_shifter_pkg.sv
// Shared definitions for the SPI master byte engine: state encoding,
// exchange geometry and the bit-order helpers used by the shifter.
package spi_byte_shifter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int         HALF_TICKS = 16;
  localparam logic [3:0] LAST_HC    = 4'(HALF_TICKS - 1);
  localparam logic [7:0] IDLE_BYTE  = 8'hFF;

  // Bit that goes on the wire first for a given byte and bit order.
  function automatic logic lead_bit(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? b[0] : b[7];
  endfunction

  // Advance the transmit register by one bit toward the wire.
  function automatic logic [7:0] shift_out(input logic [7:0] b, input logic lsb_first);
    return lsb_first ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
  endfunction

  // Accumulate one received bit so the first bit ends up at the lead position.
  function automatic logic [7:0] shift_in(input logic [7:0] b, input logic s,
                                          input logic lsb_first);
    return lsb_first ? {s, b[7:1]} : {b[6:0], s};
  endfunction

endpackage

// File: rtl/spi_byte_shifter_tick.sv
// SCK half-period tick generator: edge detect on the divided clock, or a
// tick every cycle when the divider is bypassed.
module spi_tick_detect (
  input  logic clk,
  input  logic reset,
  input  logic serclk,
  input  logic fast,
  output logic tick
);

  logic ser_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ser_q <= 1'b0;
    end else begin
      ser_q <= serclk;
    end
  end

  // Either edge of the divided clock marks one half-period.
  assign tick = fast | (serclk ^ ser_q);

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 master byte engine: one CPU write runs one full-duplex 8-bit
// exchange paced by the divider ticks, then reports the received byte.
module spi_byte_shifter
  import spi_byte_shifter_pkg::*;
#(
  parameter logic LSB_FIRST = 1'b0,
  parameter logic IDLE_MOSI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serclk,
  input  logic       fast,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd_status,
  output logic [7:0] dout,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output state_t     dbg_state
);

  // Handshake: wr is a one-cycle request accepted only while busy=0; din is
  // captured on the accepting edge. A wr seen while busy=1 is dropped and
  // latched into overrun. done pulses for one cycle on the edge busy falls,
  // so a wr in the done cycle is accepted and the next exchange starts.

  state_t     state, state_n;
  logic [7:0] tx_sr, tx_n;
  logic [7:0] rx_sr, rx_n;
  logic [3:0] hc, hc_n;
  logic [7:0] dout_n;
  logic       busy_n, done_n, overrun_n, sck_n, mosi_n;
  logic       tick;

  spi_tick_detect u_tick (
    .clk    (clk),
    .reset  (reset),
    .serclk (serclk),
    .fast   (fast),
    .tick   (tick)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      hc       <= '0;
      dout     <= IDLE_BYTE;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      spi_sck  <= 1'b0;
      spi_mosi <= IDLE_MOSI;
    end else begin
      state    <= state_n;
      tx_sr    <= tx_n;
      rx_sr    <= rx_n;
      hc       <= hc_n;
      dout     <= dout_n;
      busy     <= busy_n;
      done     <= done_n;
      overrun  <= overrun_n;
      spi_sck  <= sck_n;
      spi_mosi <= mosi_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx_sr;
    rx_n      = rx_sr;
    hc_n      = hc;
    dout_n    = dout;
    busy_n    = busy;
    done_n    = 1'b0;
    overrun_n = overrun;
    sck_n     = spi_sck;
    mosi_n    = spi_mosi;

    // A dropped write outranks a status read in the same cycle.
    if (wr && busy) begin
      overrun_n = 1'b1;
    end else if (rd_status) begin
      overrun_n = 1'b0;
    end

    case (state)
      ST_IDLE: begin
        sck_n = 1'b0;
        if (wr) begin
          tx_n    = din;
          rx_n    = '0;
          mosi_n  = lead_bit(din, LSB_FIRST);
          busy_n  = 1'b1;
          state_n = ST_SETUP;
        end
      end

      ST_SETUP: begin
        sck_n = 1'b0;
        if (tick) begin
          hc_n    = '0;
          state_n = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          hc_n = hc + 4'd1;
          if (!hc[0]) begin
            // Leading (rising) edge: slave data is sampled here.
            sck_n = 1'b1;
            rx_n  = shift_in(rx_sr, spi_miso, LSB_FIRST);
          end else begin
            sck_n = 1'b0;
            if (hc != LAST_HC) begin
              tx_n   = shift_out(tx_sr, LSB_FIRST);
              mosi_n = lead_bit(shift_out(tx_sr, LSB_FIRST), LSB_FIRST);
            end else begin
              hc_n    = '0;
              dout_n  = rx_sr;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              mosi_n  = IDLE_MOSI;
              state_n = ST_IDLE;
            end
          end
        end
      end

      default: begin
        sck_n   = 1'b0;
        busy_n  = 1'b0;
        mosi_n  = IDLE_MOSI;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Bench for spi_byte_shifter: behavioural SPI slave, MOSI byte monitor and
// a timing model derived from the tick-count rules of the exchange.
module tb_spi_byte_shifter;
  import spi_byte_shifter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] div_cnt = 8'd0;
  int         div_bit = 3;
  logic       serclk;
  always @(posedge clk) div_cnt <= div_cnt + 8'd1;
  assign serclk = div_cnt[div_bit[2:0]];

  // ---------------- DUT (MSB first) ----------------
  logic       fast = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'd0;
  logic       rd_status = 1'b0;
  logic [7:0] dout;
  logic       busy, done, overrun, spi_sck, spi_mosi, spi_miso;
  state_t     dbg_state;

  logic       loopback = 1'b1;
  logic [7:0] slave_byte = 8'hFF;
  int         slave_idx = 0;

  assign spi_miso = loopback ? spi_mosi :
                    ((slave_idx < 8) ? slave_byte[3'(7 - slave_idx)] : 1'b1);

  spi_byte_shifter dut (
    .clk(clk), .reset(reset), .serclk(serclk), .fast(fast), .wr(wr), .din(din),
    .rd_status(rd_status), .dout(dout), .busy(busy), .done(done), .overrun(overrun),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .dbg_state(dbg_state)
  );

  // ---------------- DUT (LSB first, loopback) ----------------
  logic       wr2 = 1'b0;
  logic [7:0] din2 = 8'd0;
  logic [7:0] dout2;
  logic       busy2, done2, overrun2, sck2, mosi2;
  state_t     dbg_state2;

  spi_byte_shifter #(.LSB_FIRST(1'b1), .IDLE_MOSI(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .serclk(serclk), .fast(fast), .wr(wr2), .din(din2),
    .rd_status(1'b0), .dout(dout2), .busy(busy2), .done(done2), .overrun(overrun2),
    .spi_sck(sck2), .spi_mosi(mosi2), .spi_miso(mosi2), .dbg_state(dbg_state2)
  );

  // ---------------- monitors / scoreboard ----------------
  logic [7:0] cur_byte = 8'd0;
  int         nbits = 0;
  int         sck_rises = 0;
  time        prev_rise = 0, last_rise = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  logic       lsb_bits[$];

  always @(posedge spi_sck) begin
    cur_byte  = {cur_byte[6:0], spi_mosi};
    nbits++;
    sck_rises++;
    prev_rise = last_rise;
    last_rise = $time;
    if (nbits == 8) begin
      obs_q.push_back(cur_byte);
      nbits = 0;
    end
  end

  always @(negedge spi_sck) slave_idx++;
  always @(negedge clk) if (done) done_cnt++;
  always @(posedge sck2) lsb_bits.push_back(mosi2);

  int tests = 0;
  int fails = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    nbits = 0;
    sck_rises = 0;
    done_cnt = 0;
    slave_idx = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input logic [7:0] b);
    @(negedge clk);
    wr  = 1'b1;
    din = b;
    @(negedge clk);
    wr  = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [12:0] got;
    int rises_at_reset;
    @(negedge clk);
    got = {dout, busy, done, overrun, spi_sck, spi_mosi};
    tests++;
    if (got !== {8'hFF, 5'b00001} || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %h state %0d, expected %h state 0", got, dbg_state, {8'hFF, 5'b00001});
    end
    reset = 1'b1;
    fast = 1'b1;
    loopback = 1'b1;
    clear_mon();
    do_write(8'h3C);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    got = {dout, busy, done, overrun, spi_sck, spi_mosi};
    tests++;
    if (got !== {8'hFF, 5'b00001} || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_mid_exchange: got %h state %0d, expected %h state 0", got, dbg_state, {8'hFF, 5'b00001});
    end
    rises_at_reset = sck_rises;
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    tests++;
    if (done_cnt !== 0 || busy !== 1'b0 || sck_rises !== rises_at_reset || dout !== 8'hFF) begin
      fails++;
      $display("FAIL reset_no_done: got done_cnt=%0d busy=%b rises=%0d dout=%h, expected 0 0 %0d FF",
               done_cnt, busy, sck_rises, rises_at_reset, dout);
    end
  endtask

  task automatic test_fast_loopback();
    int cyc;
    logic [7:0] o, e;
    fast = 1'b1;
    loopback = 1'b1;
    clear_mon();
    exp_q.push_back(8'hA5);
    do_write(8'hA5);
    wait_idle(cyc);
    tests++;
    if (cyc !== 17) begin
      fails++;
      $display("FAIL fast_busy_len: got %0d clk, expected 17", cyc);
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL fast_done_pulse: got done=%b when busy fell, expected 1", done);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (sck_rises !== 8 || done_cnt !== 1) begin
      fails++;
      $display("FAIL fast_sck_done_count: got rises=%0d done=%0d, expected 8 1", sck_rises, done_cnt);
    end
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
    e = exp_q.pop_front();
    tests++;
    if (o !== e || dout !== 8'hA5) begin
      fails++;
      $display("FAIL fast_loopback_data: got mosi=%h dout=%h, expected %h A5", o, dout, e);
    end
  endtask

  task automatic test_divided();
    int cyc;
    logic [7:0] o;
    fast = 1'b0;
    div_bit = 3;
    loopback = 1'b0;
    slave_byte = 8'h5A;
    repeat (40) @(negedge clk);
    clear_mon();
    do_write(8'hC3);
    wait_idle(cyc);
    tests++;
    if (cyc < 129 || cyc > 136) begin
      fails++;
      $display("FAIL div_busy_len: got %0d clk, expected 129..136", cyc);
    end
    tests++;
    if (last_rise - prev_rise !== 160) begin
      fails++;
      $display("FAIL div_sck_period: got %0t, expected 160 (16 clk)", last_rise - prev_rise);
    end
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
    tests++;
    if (o !== 8'hC3 || dout !== 8'h5A) begin
      fails++;
      $display("FAIL div_data: got slave_rx=%h dout=%h, expected C3 5A", o, dout);
    end
  endtask

  task automatic test_overrun();
    int cyc;
    logic [7:0] o;
    fast = 1'b1;
    loopback = 1'b0;
    slave_byte = 8'h99;
    repeat (10) @(negedge clk);
    clear_mon();
    do_write(8'h11);
    repeat (6) @(negedge clk);
    do_write(8'h22);
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b, expected 1", overrun);
    end
    wait_idle(cyc);
    repeat (2) @(negedge clk);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
    tests++;
    if (o !== 8'h11 || dout !== 8'h99 || done_cnt !== 1 || obs_q.size() !== 0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_undisturbed: got mosi=%h dout=%h done=%0d extra=%0d ovr=%b, expected 11 99 1 0 1",
               o, dout, done_cnt, obs_q.size(), overrun);
    end
    @(negedge clk);
    rd_status = 1'b1;
    @(negedge clk);
    rd_status = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clear: got %b, expected 0", overrun);
    end
    clear_mon();
    do_write(8'h44);
    repeat (3) @(negedge clk);
    @(negedge clk);
    wr = 1'b1;
    din = 8'h55;
    rd_status = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    rd_status = 1'b0;
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set_wins: got %b, expected 1", overrun);
    end
    wait_idle(cyc);
    o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
    tests++;
    if (o !== 8'h44) begin
      fails++;
      $display("FAIL overrun_second_tx: got %h, expected 44", o);
    end
    @(negedge clk);
    rd_status = 1'b1;
    @(negedge clk);
    rd_status = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc, k;
    logic [7:0] o, e;
    fast = 1'b1;
    loopback = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    exp_q.push_back(8'hC7);
    do_write(8'hC7);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done_cycle: got done=%b busy=%b, expected 1 0", done, busy);
    end
    wr = 1'b1;
    din = 8'h01;
    exp_q.push_back(8'h01);
    @(negedge clk);
    wr = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: got busy=%b, expected 1", busy);
    end
    wait_idle(cyc);
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt !== 2 || dout !== 8'h01 || obs_q.size() !== 2) begin
      fails++;
      $display("FAIL b2b_counts: got done=%0d dout=%h bytes=%0d, expected 2 01 2", done_cnt, dout, obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL b2b_order: got %h, expected %h", o, e);
      end
    end
  endtask

  task automatic test_lsb_first();
    int cyc;
    logic [7:0] got, tx;
    fast = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tx = (n == 0) ? 8'h01 : 8'($urandom_range(0, 255));
      lsb_bits.delete();
      @(negedge clk);
      wr2 = 1'b1;
      din2 = tx;
      @(negedge clk);
      wr2 = 1'b0;
      cyc = 0;
      while (busy2 && cyc < 5000) begin
        cyc++;
        @(negedge clk);
      end
      got = 8'hxx;
      if (lsb_bits.size() == 8) begin
        for (int i = 0; i < 8; i++) got[i] = lsb_bits[i];
      end
      tests++;
      if (cyc !== 17 || got !== tx || dout2 !== tx) begin
        fails++;
        $display("FAIL lsb_first: got len=%0d mosi=%h dout=%h, expected 17 %h %h", cyc, got, dout2, tx, tx);
      end
    end
  endtask

  task automatic test_random();
    int cyc, mode, lo, hi;
    logic [7:0] tx, sb, o;
    for (int n = 0; n < 20; n++) begin
      mode = $urandom_range(0, 4);
      fast = (mode == 0);
      div_bit = (mode == 0) ? 0 : mode - 1;
      lo = (mode == 0) ? 17 : 16 * (1 << div_bit) + 1;
      hi = (mode == 0) ? 17 : 17 * (1 << div_bit);
      loopback = 1'b0;
      sb = 8'($urandom_range(0, 255));
      tx = 8'($urandom_range(0, 255));
      slave_byte = sb;
      repeat (20 + $urandom_range(0, 3)) @(negedge clk);
      clear_mon();
      do_write(tx);
      wait_idle(cyc);
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      tests++;
      if (cyc < lo || cyc > hi || o !== tx || dout !== sb) begin
        fails++;
        $display("FAIL random[%0d]: got len=%0d mosi=%h dout=%h, expected %0d..%0d %h %h",
                 n, cyc, o, dout, lo, hi, tx, sb);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_fast_loopback();
    test_divided();
    test_overrun();
    test_back_to_back();
    test_lsb_first();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
